// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster coordinate type, default SVGA timing and RGB pixel struct
package video_timing_pkg;

  typedef logic [11:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 23;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/alpha_blend8.sv
// rtl/alpha_blend8.sv - one 8-bit colour channel alpha blend, two registered stages
module alpha_blend8
  import video_timing_pkg::*;
(
  input  logic       pxlClk,
  input  logic       rst,
  input  logic [7:0] fg,
  input  logic [7:0] bg,
  input  logic [7:0] a,
  output logic [7:0] out
);

  logic [7:0]  inv_a;
  logic [15:0] prod_fg;
  logic [15:0] prod_bg;
  logic [15:0] sum_q;
  logic [15:0] t;

  // weighted sum never exceeds 255*255, so 16 bits hold it without overflow
  always_comb begin
    inv_a   = 8'd255 - a;
    prod_fg = {8'd0, a} * {8'd0, fg};
    prod_bg = {8'd0, inv_a} * {8'd0, bg};
    t       = sum_q + 16'd128;
  end

  // stage 1 holds the weighted sum, stage 2 the rounded divide-by-255
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      out   <= '0;
    end else begin
      sum_q <= prod_fg + prod_bg;
      out   <= 8'((t + (t >> 8)) >> 8);
    end
  end

endmodule

// File: rtl/raster_overlay_mixer.sv
// rtl/raster_overlay_mixer.sv - raster timing master and overlay alpha mixer; MIXER_FRAME_CNT_EN adds frame_cnt
module raster_overlay_mixer
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned SRC_LAT  = 0
) (
  input  logic        pxlClk,
  input  logic        rst,
  output logic [11:0] hcnt,
  output logic [11:0] vcnt,
  output logic [11:0] hsize,
  output logic [11:0] vsize,
  input  logic [7:0]  pixel_r_in,
  input  logic [7:0]  pixel_g_in,
  input  logic [7:0]  pixel_b_in,
  input  logic [7:0]  pixel_a_in,
  input  logic [7:0]  bg_r,
  input  logic [7:0]  bg_g,
  input  logic [7:0]  bg_b,
  input  logic        blend_en,
  output logic [7:0]  vid_r,
  output logic [7:0]  vid_g,
  output logic [7:0]  vid_b,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de
`ifdef MIXER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t H_SS_C   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SE_C   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_LAST_C = coord_t'(H_TOTAL - 1);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t V_SS_C   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SE_C   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t V_LAST_C = coord_t'(V_TOTAL - 1);

  typedef struct packed {
    rgb8_t bg;
    logic  de;
    logic  hs;
    logic  vs;
    logic  en;
  } align_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } ctl_t;

  logic   h_wrap;
  logic   v_wrap;
  logic   en_q;
  align_t stage_in;
  align_t aligned;
  ctl_t   ctl1_q;
  ctl_t   ctl2_q;
  logic [7:0] a_eff;
  logic [7:0] blend_r;
  logic [7:0] blend_g;
  logic [7:0] blend_b;

  assign hsize = H_ACT_C;
  assign vsize = V_ACT_C;

  // raster decode for the current position, sync kept active-high until the output
  always_comb begin
    h_wrap         = (hcnt == H_LAST_C);
    v_wrap         = (vcnt == V_LAST_C);
    stage_in.bg.r  = bg_r;
    stage_in.bg.g  = bg_g;
    stage_in.bg.b  = bg_b;
    stage_in.de    = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    stage_in.hs    = (hcnt >= H_SS_C) && (hcnt < H_SE_C);
    stage_in.vs    = (vcnt >= V_SS_C) && (vcnt < V_SE_C);
    stage_in.en    = en_q;
  end

  // raster counters; blend_en is only taken at the frame wrap so a frame never tears
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
      en_q <= 1'b0;
    end else begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? '0 : vcnt + 12'd1;
      end else begin
        hcnt <= hcnt + 12'd1;
      end
      if (h_wrap && v_wrap) begin
        en_q <= blend_en;
      end
    end
  end

  generate
    if (SRC_LAT == 0) begin : g_no_delay
      assign aligned = stage_in;
    end else begin : g_delay
      align_t dly_q [SRC_LAT];

      // background and timing wait here for the overlay source to return its pixel
      always_ff @(posedge pxlClk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < SRC_LAT; i++) begin
            dly_q[i] <= '0;
          end
        end else begin
          dly_q[0] <= stage_in;
          for (int i = 1; i < SRC_LAT; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign aligned = dly_q[SRC_LAT-1];
    end
  endgenerate

  assign a_eff = aligned.en ? pixel_a_in : 8'd0;

  alpha_blend8 u_blend_r (
    .pxlClk (pxlClk),
    .rst    (rst),
    .fg     (pixel_r_in),
    .bg     (aligned.bg.r),
    .a      (a_eff),
    .out    (blend_r)
  );

  alpha_blend8 u_blend_g (
    .pxlClk (pxlClk),
    .rst    (rst),
    .fg     (pixel_g_in),
    .bg     (aligned.bg.g),
    .a      (a_eff),
    .out    (blend_g)
  );

  alpha_blend8 u_blend_b (
    .pxlClk (pxlClk),
    .rst    (rst),
    .fg     (pixel_b_in),
    .bg     (aligned.bg.b),
    .a      (a_eff),
    .out    (blend_b)
  );

  // timing follows the two blend stages so it stays aligned with the mixed pixel
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      ctl1_q <= '0;
      ctl2_q <= '0;
    end else begin
      ctl1_q <= '{de: aligned.de, hs: aligned.hs, vs: aligned.vs};
      ctl2_q <= ctl1_q;
    end
  end

  assign vid_de = ctl2_q.de;
  assign vid_hs = SYNC_POL ? ctl2_q.hs : ~ctl2_q.hs;
  assign vid_vs = SYNC_POL ? ctl2_q.vs : ~ctl2_q.vs;
  assign vid_r  = ctl2_q.de ? blend_r : 8'd0;
  assign vid_g  = ctl2_q.de ? blend_g : 8'd0;
  assign vid_b  = ctl2_q.de ? blend_b : 8'd0;

`ifdef MIXER_FRAME_CNT_EN
  // completed-frame counter, independent of blend_en
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_raster_overlay_mixer.sv
// tb/tb_raster_overlay_mixer.sv - randomized bench for raster_overlay_mixer against a behavioural mixer model
module tb_raster_overlay_mixer;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 10, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int LAT = 2;
  localparam int MAXC = 4096;
  localparam int DHT = 1056;

  logic pxlClk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] hcnt, vcnt, hsize, vsize;
  logic [7:0] pixel_r_in, pixel_g_in, pixel_b_in, pixel_a_in;
  logic [7:0] bg_r, bg_g, bg_b;
  logic blend_en;
  logic [7:0] vid_r, vid_g, vid_b;
  logic vid_hs, vid_vs, vid_de;
  logic [11:0] d_hcnt, d_vcnt, d_hsize, d_vsize;
  logic [7:0] d_r, d_g, d_b;
  logic d_hs, d_vs, d_de;
`ifdef MIXER_FRAME_CNT_EN
  logic [15:0] frame_cnt, d_frame_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int n = 0;
  int phase = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  int fr_h [MAXC];
  int fg_h [MAXC];
  int fb_h [MAXC];
  int a_h  [MAXC];
  int br_h [MAXC];
  int bgg_h[MAXC];
  int bb_h [MAXC];
  int en_h [MAXC];

  always #5 pxlClk = ~pxlClk;

  raster_overlay_mixer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .SRC_LAT(LAT)
  ) dut (
    .pxlClk(pxlClk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .hsize(hsize), .vsize(vsize),
    .pixel_r_in(pixel_r_in), .pixel_g_in(pixel_g_in), .pixel_b_in(pixel_b_in), .pixel_a_in(pixel_a_in),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .blend_en(blend_en),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de)
`ifdef MIXER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  raster_overlay_mixer u_dflt (
    .pxlClk(pxlClk), .rst(rst), .hcnt(d_hcnt), .vcnt(d_vcnt), .hsize(d_hsize), .vsize(d_vsize),
    .pixel_r_in(pixel_r_in), .pixel_g_in(pixel_g_in), .pixel_b_in(pixel_b_in), .pixel_a_in(pixel_a_in),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .blend_en(blend_en),
    .vid_r(d_r), .vid_g(d_g), .vid_b(d_b), .vid_hs(d_hs), .vid_vs(d_vs), .vid_de(d_de)
`ifdef MIXER_FRAME_CNT_EN
    , .frame_cnt(d_frame_cnt)
`endif
  );

  function automatic int ref_blend(int a, int fg, int bg);
    int s;
    s = a * fg + (255 - a) * bg;
    return (2 * s + 255) / 510;
  endfunction

  function automatic int pos(int h, int v, int f);
    return f * FRAME + v * HT + h;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
    end
  endtask

  task automatic drive(int c);
    int sel, f, r;
    int fr, fgv, fb, a, br, bgv, bb, en;
    fr = $urandom_range(0, 255); fgv = $urandom_range(0, 255); fb = $urandom_range(0, 255);
    br = $urandom_range(0, 255); bgv = $urandom_range(0, 255); bb = $urandom_range(0, 255);
    sel = $urandom_range(0, 3);
    a = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
    en = $urandom_range(0, 1);
    if (phase == 1) begin
      f = c / FRAME;
      r = c % FRAME;
      if (f == 0) en = 1;
      else if (f == 1) en = (r < 5 * HT) ? 1 : 0;
      if (c == pos(0, 0, 1) + LAT) begin fr = 'hA5; fgv = 'hA5; fb = 'hA5; a = 255; end
      if (c == pos(3, 1, 1)) begin br = 'hEE; bgv = 'hEE; bb = 'hEE; end
      if (c == pos(3, 1, 1) + LAT) begin fr = 'h12; fgv = 'h12; fb = 'h12; a = 255; end
      if (c == pos(5, 1, 1)) begin br = 'hEE; bgv = 'hEE; bb = 'hEE; end
      if (c == pos(5, 1, 1) + LAT) a = 0;
      if (c == pos(7, 1, 1)) begin br = 0; bgv = 0; bb = 0; end
      if (c == pos(7, 1, 1) + LAT) begin fr = 'hFF; fgv = 'hFF; fb = 'hFF; a = 'h80; end
      if (c == pos(3, 1, 2)) begin br = 'hEE; bgv = 'hEE; bb = 'hEE; end
      if (c == pos(3, 1, 2) + LAT) begin fr = 'h12; fgv = 'h12; fb = 'h12; a = 255; end
    end
    fr_h[c] = fr; fg_h[c] = fgv; fb_h[c] = fb; a_h[c] = a;
    br_h[c] = br; bgg_h[c] = bgv; bb_h[c] = bb; en_h[c] = en;
    pixel_r_in = 8'(fr); pixel_g_in = 8'(fgv); pixel_b_in = 8'(fb); pixel_a_in = 8'(a);
    bg_r = 8'(br); bg_g = 8'(bgv); bg_b = 8'(bb); blend_en = en[0];
  endtask

  task automatic step();
    drive(n);
    @(posedge pxlClk);
    #1;
    n++;
  endtask

  // single compare process: reset values while rst is low, behavioural model otherwise
  always @(negedge pxlClk) begin
    int q, f, r, h, v, a, er, eg, eb, p;
    int de, hs, vs, en, dde, dhs;
    if (!rst) begin
      chk("rst_de", vid_de, 0); chk("rst_hs", vid_hs, 0); chk("rst_vs", vid_vs, 0);
      chk("rst_r", vid_r, 0); chk("rst_g", vid_g, 0); chk("rst_b", vid_b, 0);
      chk("rst_hcnt", hcnt, 0); chk("rst_vcnt", vcnt, 0);
`ifdef MIXER_FRAME_CNT_EN
      chk("rst_frame_cnt", frame_cnt, 0);
`endif
    end else if (phase != 0) begin
      chk("hcnt", hcnt, n % HT);
      chk("vcnt", vcnt, (n / HT) % VT);
      if (n < LAT + 2) begin
        de = 0; hs = 0; vs = 0; er = 0; eg = 0; eb = 0;
      end else begin
        q = n - LAT - 2;
        f = q / FRAME; r = q % FRAME; h = r % HT; v = r / HT;
        de = (h < HA && v < VA) ? 1 : 0;
        hs = (h >= HA + HFP && h < HA + HFP + HS) ? 1 : 0;
        vs = (v >= VA + VFP && v < VA + VFP + VS) ? 1 : 0;
        en = (f == 0) ? 0 : en_h[f * FRAME - 1];
        a = (en != 0) ? a_h[n - 2] : 0;
        er = (de != 0) ? ref_blend(a, fr_h[n - 2], br_h[q]) : 0;
        eg = (de != 0) ? ref_blend(a, fg_h[n - 2], bgg_h[q]) : 0;
        eb = (de != 0) ? ref_blend(a, fb_h[n - 2], bb_h[q]) : 0;
      end
      chk("vid_de", vid_de, de); chk("vid_hs", vid_hs, hs); chk("vid_vs", vid_vs, vs);
      chk("vid_r", vid_r, er); chk("vid_g", vid_g, eg); chk("vid_b", vid_b, eb);
`ifdef MIXER_FRAME_CNT_EN
      chk("frame_cnt", frame_cnt, (n / FRAME) % 65536);
`endif
      if (phase == 1) begin
        if (n >= LAT + 2 + FRAME && n < LAT + 2 + 2 * FRAME) begin
          de_cnt += int'(vid_de); hs_cnt += int'(vid_hs); vs_cnt += int'(vid_vs);
        end
        if (n == pos(0, 0, 1) + LAT + 1) chk("marker_de_early", vid_de, 0);
        if (n == pos(0, 0, 1) + LAT + 2) begin
          chk("marker_de", vid_de, 1); chk("marker_pix", vid_r, 'hA5);
        end
        if (n == pos(3, 1, 1) + LAT + 2) chk("lit_opaque", vid_r, 'h12);
        if (n == pos(5, 1, 1) + LAT + 2) chk("lit_transparent", vid_g, 'hEE);
        if (n == pos(7, 1, 1) + LAT + 2) chk("lit_half", vid_b, 'h80);
        if (n == pos(3, 1, 2) + LAT + 2) chk("lit_blend_off", vid_r, 'hEE);
      end
      if (n < 2 * DHT) begin
        chk("d_hcnt", d_hcnt, n % DHT);
        chk("d_vcnt", d_vcnt, n / DHT);
        if (n < 2) begin
          dde = 0; dhs = 0;
        end else begin
          p = (n - 2) % DHT;
          dde = (p < 800) ? 1 : 0;
          dhs = (p >= 840 && p < 968) ? 1 : 0;
        end
        chk("d_de", d_de, dde); chk("d_hs", d_hs, dhs); chk("d_vs", d_vs, 0);
        if (!d_de) chk("d_rgb_blank", int'(d_r) + int'(d_g) + int'(d_b), 0);
      end
    end
  end

  initial begin
    drive(0);
    chk("model_opaque", ref_blend('hFF, 'h12, 'hEE), 'h12);
    chk("model_transparent", ref_blend(0, 'h12, 'hEE), 'hEE);
    chk("model_half", ref_blend('h80, 'hFF, 0), 'h80);
    repeat (5) @(posedge pxlClk);
    #1;
    chk("hsize", hsize, HA); chk("vsize", vsize, VA);
    chk("d_hsize", d_hsize, 800); chk("d_vsize", d_vsize, 600);
    rst = 1'b1;
    n = 0;
    phase = 1;
    while (n < pos(10, 4, 3)) step();
    drive(n);
    chk("pre_rst_hcnt", hcnt, 10); chk("pre_rst_vcnt", vcnt, 4);
    chk("frame_de_count", de_cnt, HA * VA);
    chk("frame_hs_count", hs_cnt, HS * VT);
    chk("frame_vs_count", vs_cnt, VS * HT);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_hcnt", hcnt, 0); chk("async_rst_vcnt", vcnt, 0);
    chk("async_rst_de", vid_de, 0); chk("async_rst_r", vid_r, 0);
    chk("async_rst_hs", vid_hs, 0);
`ifdef MIXER_FRAME_CNT_EN
    chk("async_rst_frame_cnt", frame_cnt, 0);
`endif
    repeat (3) @(posedge pxlClk);
    #1;
    phase = 2;
    n = 0;
    rst = 1'b1;
    repeat (FRAME + 40) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
